// File: rtl/conv_frame_sequencer.sv
// Walks the interior of a zero-padded input frame in raster order and tracks
// output pixel addresses, raising a sticky overflow if outputs outrun inputs.
module conv_frame_sequencer #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 180,
  parameter int PAD    = 3,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  input  logic              pe_valid,
  output logic              issue,
  output logic [ADDR_W-1:0] in_addr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [1:0]        dbg_state
);

  localparam int PW     = IMG_W + 2*PAD;
  localparam int N      = IMG_W * IMG_H;
  localparam int BASE_I = PAD*PW + PAD;
  localparam int CNT_W  = $clog2(N + 1);
  localparam int COL_W  = $clog2(IMG_W);

  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_I);
  localparam logic [ADDR_W-1:0] WRAP_A = ADDR_W'(2*PAD + 1);
  localparam logic [CNT_W-1:0]  LAST_C = CNT_W'(N - 1);
  localparam logic [COL_W-1:0]  COL_E  = COL_W'(IMG_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // Handshake: issue/in_addr form a one-way valid with stall as backpressure
  // (no issue while stall=1); pe_valid is a one-way valid with no ready, so an
  // output arriving before its input has been issued is flagged, not held.
  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_in_addr;
  logic [ADDR_W-1:0]   r_out_addr;
  logic [CNT_W-1:0]    r_iss_cnt;
  logic [CNT_W-1:0]    r_out_cnt;
  logic [COL_W-1:0]    r_col;
  logic                r_done;
  logic                r_overflow;

  logic w_issue;
  logic w_last_issue;
  logic w_pe_ok;
  logic w_pe_err;
  logic w_last_out;
  logic w_launch;

  always_comb begin
    w_issue      = (r_state == S_RUN) && !stall;
    w_last_issue = w_issue && (r_iss_cnt == LAST_C);
    w_pe_ok      = pe_valid && (r_state != S_IDLE) && (r_out_cnt < r_iss_cnt);
    w_pe_err     = pe_valid && !w_pe_ok;
    w_last_out   = w_pe_ok && (r_out_cnt == LAST_C);
    w_launch     = (r_state == S_IDLE) && start;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN: begin
        if (w_last_out)        w_state_nxt = S_IDLE;
        else if (w_last_issue) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: if (w_last_out) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_addr  <= BASE_A;
      r_out_addr <= '0;
      r_iss_cnt  <= '0;
      r_out_cnt  <= '0;
      r_col      <= '0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= w_last_out;
      if (w_pe_err) r_overflow <= 1'b1;
      if (w_launch) begin
        r_in_addr  <= BASE_A;
        r_out_addr <= '0;
        r_iss_cnt  <= '0;
        r_out_cnt  <= '0;
        r_col      <= '0;
      end else begin
        if (w_issue) begin
          r_iss_cnt <= r_iss_cnt + 1'b1;
          // The final address is held so it stays visible through drain.
          if (!w_last_issue) begin
            if (r_col == COL_E) begin
              r_in_addr <= r_in_addr + WRAP_A;
              r_col     <= '0;
            end else begin
              r_in_addr <= r_in_addr + 1'b1;
              r_col     <= r_col + 1'b1;
            end
          end
        end
        if (w_pe_ok) begin
          r_out_cnt <= r_out_cnt + 1'b1;
          if (!w_last_out) r_out_addr <= r_out_addr + 1'b1;
        end
      end
    end
  end

  assign issue     = w_issue;
  assign in_addr   = r_in_addr;
  assign out_addr  = r_out_addr;
  assign busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done      = r_done;
  assign overflow  = r_overflow;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Directed bench: a 3x2/PAD=1 instance driven from a cycle table plus corner
// sequences, and a default-size instance run through one full frame.
module tb_conv_frame_sequencer;

  logic clk;
  logic rst;

  logic       s_start, s_stall, s_pv;
  logic       s_issue, s_busy, s_done, s_ovf;
  logic [5:0] s_in, s_out;
  logic [1:0] s_dbg;

  logic        b_start, b_stall, b_pv;
  logic        b_issue, b_busy, b_done, b_ovf;
  logic [13:0] b_in, b_out;
  logic [1:0]  b_dbg;

  int n_cmp = 0;
  int n_err = 0;

  conv_frame_sequencer #(.IMG_W(3), .IMG_H(2), .PAD(1), .ADDR_W(6)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .stall(s_stall), .pe_valid(s_pv),
    .issue(s_issue), .in_addr(s_in), .out_addr(s_out), .busy(s_busy),
    .done(s_done), .overflow(s_ovf), .dbg_state(s_dbg)
  );

  conv_frame_sequencer u_big (
    .clk(clk), .rst(rst), .start(b_start), .stall(b_stall), .pe_valid(b_pv),
    .issue(b_issue), .in_addr(b_in), .out_addr(b_out), .busy(b_busy),
    .done(b_done), .overflow(b_ovf), .dbg_state(b_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start, stall, pv;
    logic       e_issue;
    logic [5:0] e_in, e_out;
    logic       e_busy, e_done, e_ovf;
  } vec_t;

  vec_t tv[17];

  function automatic vec_t mk(logic st, logic sl, logic pv, logic ei,
                              int ein, int eout, logic eb, logic ed, logic eo);
    vec_t v;
    v.start = st; v.stall = sl; v.pv = pv; v.e_issue = ei;
    v.e_in = 6'(ein); v.e_out = 6'(eout);
    v.e_busy = eb; v.e_done = ed; v.e_ovf = eo;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_small(input string tag, input logic ei, input int ein, input int eout,
                           input logic eb, input logic ed, input logic eo);
    chk({tag, " issue"},    32'(s_issue), 32'(ei));
    chk({tag, " in_addr"},  32'(s_in),    32'(ein));
    chk({tag, " out_addr"}, 32'(s_out),   32'(eout));
    chk({tag, " busy"},     32'(s_busy),  32'(eb));
    chk({tag, " done"},     32'(s_done),  32'(ed));
    chk({tag, " overflow"}, 32'(s_ovf),   32'(eo));
  endtask

  // Big-frame constants: PW=70, BASE=213, N=11520.
  localparam int B_PW   = 70;
  localparam int B_BASE = 213;
  localparam int B_N    = 11520;

  initial begin
    int iss_n, out_n, done_n, row, col, post;
    int first_in, last_in, prev_in, after_276;
    logic busy_at_done;

    rst = 1'b1;
    s_start = 0; s_stall = 0; s_pv = 0;
    b_start = 0; b_stall = 0; b_pv = 0;

    // start,stall,pv | issue,in_addr,out_addr,busy,done,overflow
    tv[0]  = mk(1,0,0, 0, 6, 0,0,0,0);
    tv[1]  = mk(0,0,0, 1, 6, 0,1,0,0);
    tv[2]  = mk(0,1,0, 0, 7, 0,1,0,0);
    tv[3]  = mk(0,1,0, 0, 7, 0,1,0,0);
    tv[4]  = mk(0,1,0, 0, 7, 0,1,0,0);
    tv[5]  = mk(0,0,0, 1, 7, 0,1,0,0);
    tv[6]  = mk(0,0,0, 1, 8, 0,1,0,0);
    tv[7]  = mk(0,0,1, 1,11, 0,1,0,0);
    tv[8]  = mk(0,0,1, 1,12, 1,1,0,0);
    tv[9]  = mk(0,0,1, 1,13, 2,1,0,0);
    tv[10] = mk(0,1,1, 0,13, 3,1,0,0);
    tv[11] = mk(1,0,1, 0,13, 4,1,0,0);
    tv[12] = mk(0,0,1, 0,13, 5,1,0,0);
    tv[13] = mk(1,0,0, 0,13, 5,0,1,0);
    tv[14] = mk(0,0,1, 1, 6, 0,1,0,0);
    tv[15] = mk(0,1,0, 0, 7, 0,1,0,1);
    tv[16] = mk(0,0,0, 1, 7, 0,1,0,1);

    #3;
    chk_small("reset", 0, 6, 0, 0, 0, 0);
    chk("reset dbg_state", 32'(s_dbg), 0);
    chk("reset big in_addr", 32'(b_in), B_BASE);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      s_start = tv[i].start; s_stall = tv[i].stall; s_pv = tv[i].pv;
      #1;
      chk_small($sformatf("v%0d", i), tv[i].e_issue, int'(tv[i].e_in), int'(tv[i].e_out),
                tv[i].e_busy, tv[i].e_done, tv[i].e_ovf);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of a run, between clock edges.
    s_start = 0; s_stall = 0; s_pv = 0;
    #1;
    chk("pre-rst issue", 32'(s_issue), 1);
    chk("pre-rst in_addr", 32'(s_in), 8);
    #1 rst = 1'b1;
    #1;
    chk_small("async-rst", 0, 6, 0, 0, 0, 0);
    chk("async-rst dbg_state", 32'(s_dbg), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("post-rst idle%0d issue", i), 32'(s_issue), 0);
      @(negedge clk);
    end

    // pe_valid in IDLE: overflow, out_addr untouched.
    s_pv = 1'b1;
    @(negedge clk);
    s_pv = 1'b0;
    #1;
    chk("idle pv overflow", 32'(s_ovf), 1);
    chk("idle pv out_addr", 32'(s_out), 0);
    chk("idle pv busy", 32'(s_busy), 0);
    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    #1;
    chk("restart issue", 32'(s_issue), 1);
    chk("restart in_addr", 32'(s_in), 6);
    chk("restart overflow sticky", 32'(s_ovf), 1);
    @(negedge clk);

    // Full default-size frame.
    rst = 1'b1;
    #1 rst = 1'b0;
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    iss_n = 0; out_n = 0; done_n = 0; row = 0; col = 0; post = 0;
    first_in = -1; last_in = -1; prev_in = -1; after_276 = -1;
    busy_at_done = 1'b1;
    for (int cyc = 0; cyc < 30000 && post < 4; cyc++) begin
      b_pv = (out_n < iss_n);
      #1;
      if (b_issue) begin
        chk("big in_addr", 32'(b_in), 32'(B_BASE + row*B_PW + col));
        if (first_in < 0) first_in = int'(b_in);
        if (prev_in == 276) after_276 = int'(b_in);
        prev_in = int'(b_in);
        last_in = int'(b_in);
        iss_n++;
        if (col == 63) begin col = 0; row++; end
        else col++;
      end
      if (b_pv) begin
        chk("big out_addr", 32'(b_out), 32'(out_n));
        out_n++;
      end
      if (b_done) begin
        done_n++;
        busy_at_done = b_busy;
      end
      if (out_n == B_N) post++;
      @(negedge clk);
    end
    b_pv = 1'b0;
    chk("big first in_addr", 32'(first_in), 213);
    chk("big addr after 276", 32'(after_276), 283);
    chk("big last in_addr", 32'(last_in), 12806);
    chk("big issued count", 32'(iss_n), B_N);
    chk("big output count", 32'(out_n), B_N);
    chk("big done pulses", 32'(done_n), 1);
    chk("big busy at done", 32'(busy_at_done), 0);
    chk("big final out_addr", 32'(b_out), B_N - 1);
    chk("big overflow", 32'(b_ovf), 0);
    chk("big end issue", 32'(b_issue), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
